udp_reg_bank_ctrl: RTL

- Parametrised UDP-payload register bank controller. It decodes ASCII-framed read/write commands from an 8-bit AXI-Stream RX payload and drives a bank of REGS_NUM registers, each REG_WIDTH bits wide.
- Every request addressed to it gets an AXI-Stream TX reply: data, ack or error.
- It sits between the UDP stack payload interfaces and the user-logic control registers.
- It supersedes the fixed 4x32 controller: adds destination filtering per frame, binary register index, write ack, error replies, frame draining and a write strobe.

---
 rtl/udp_reg_bank_ctrl_pkg.sv | 15 +
 rtl/udp_reg_bank_ctrl_if.sv | 9 +
 rtl/udp_reg_bank_ctrl_serializer.sv | 41 ++++
 rtl/udp_reg_bank_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/udp_reg_bank_ctrl_pkg.sv
// udp_reg_pkg: shared ASCII codes, FSM states and reply sizing for the register bank controller
package udp_reg_pkg;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_W_UP  = 8'h57;
  localparam logic [7:0] ASC_W_LO  = 8'h77;
  localparam logic [7:0] ASC_R_UP  = 8'h52;
  localparam logic [7:0] ASC_R_LO  = 8'h72;
  localparam logic [7:0] ASC_K     = 8'h4B;
  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_E     = 8'h45;
  typedef enum logic [2:0] {S_IDLE, S_INDEX, S_CMD, S_WDATA, S_DRAIN, S_RESP} state_t;
  function automatic int reply_max_bytes(input int reg_width);
    return 1 + reg_width / 8;
  endfunction
endpackage

// File: rtl/udp_reg_bank_ctrl_if.sv
// udp_reg_bank_ctrl_if: 8-bit AXI-Stream payload channel
interface udp_reg_bank_ctrl_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_reg_bank_ctrl_serializer.sv
// udp_resp_serializer: emits a header byte then up to REG_WIDTH payload bits MSB-first over AXI-Stream
module udp_resp_serializer
  import udp_reg_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [7:0]            i_hdr,
  input  logic [REG_WIDTH-1:0]  i_payload,
  input  logic [3:0]            i_len,
  udp_reg_bank_ctrl_if.master   tx,
  output logic                  o_done
);
  logic [REG_WIDTH-1:0] sh;
  logic [3:0]           rem;
  assign o_done = tx.tvalid && tx.tready && tx.tlast;
  // load the reply, then advance one byte per handshake; outputs only move after a handshake
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx.tvalid <= 1'b0;
      tx.tlast  <= 1'b0;
      tx.tdata  <= '0;
      sh        <= '0;
      rem       <= '0;
    end else if (i_load) begin
      tx.tvalid <= 1'b1;
      tx.tdata  <= i_hdr;
      tx.tlast  <= i_len == 4'd1;
      sh        <= i_payload;
      rem       <= i_len;
    end else if (tx.tvalid && tx.tready) begin
      tx.tvalid <= !tx.tlast;
      tx.tlast  <= rem == 4'd2;
      tx.tdata  <= sh[REG_WIDTH-1 -: 8];
      sh        <= sh << 8;
      rem       <= rem - 4'd1;
    end
  end
endmodule

// File: rtl/udp_reg_bank_ctrl.sv
// udp_reg_bank_ctrl: ASCII-framed UDP register bank with read, write, ack and error replies
module udp_reg_bank_ctrl
  import udp_reg_pkg::*;
#(
  parameter int          REGS_NUM    = 8,
  parameter int          REG_WIDTH   = 32,
  parameter logic [31:0] IP_ADDRESS  = {8'd192, 8'd168, 8'd1, 8'd128},
  parameter logic [15:0] PORT_NUMBER = 16'd1234
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  udp_reg_bank_ctrl_if.slave            rx_udp_payload_axis,
  udp_reg_bank_ctrl_if.master           tx_udp_payload_axis,
  input  logic [31:0]                   i_ip_adr,
  input  logic [15:0]                   i_port_nbr,
  output logic [REGS_NUM*REG_WIDTH-1:0] o_regs,
  output logic [REGS_NUM-1:0]           o_wr_strobe
);
  localparam int         NB = REG_WIDTH / 8;
  localparam int         IW = REGS_NUM > 1 ? $clog2(REGS_NUM) : 1;
  localparam logic [8:0] RN = 9'(REGS_NUM);
  state_t               state;
  logic [REG_WIDTH-1:0] regs [REGS_NUM];
  logic [REG_WIDTH-1:0] wsh, snap, wnext;
  logic [7:0]           idx, rd, hdr;
  logic [IW-1:0]        idx_t;
  logic [3:0]           bcnt, len;
  logic                 match, err, is_wr, resp_q, hit, acc, rl, is_w, is_r, last_b, done, ld;
  assign rd     = rx_udp_payload_axis.tdata;
  assign rl     = rx_udp_payload_axis.tlast;
  assign rx_udp_payload_axis.tready = state != S_RESP;
  assign acc    = rx_udp_payload_axis.tvalid && state != S_RESP;
  assign hit    = i_ip_adr == IP_ADDRESS && i_port_nbr == PORT_NUMBER;
  assign is_w   = rd == ASC_W_UP || rd == ASC_W_LO;
  assign is_r   = rd == ASC_R_UP || rd == ASC_R_LO;
  assign idx_t  = idx[IW-1:0];
  assign wnext  = REG_WIDTH'({wsh, rd});
  assign last_b = bcnt == 4'(NB - 1);
  assign ld     = state == S_RESP && !resp_q;
  assign hdr    = err ? ASC_E : is_wr ? ASC_K : ASC_D;
  assign len    = (err || is_wr) ? 4'd1 : 4'(reply_max_bytes(REG_WIDTH));
  for (genvar k = 0; k < REGS_NUM; k++) begin : g_out
    assign o_regs[k*REG_WIDTH +: REG_WIDTH] = regs[k];
  end
  // request decoder: frame filtering, index/command parsing, write commit and reply hand-off
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      match       <= 1'b0;
      err         <= 1'b0;
      is_wr       <= 1'b0;
      idx         <= '0;
      bcnt        <= '0;
      wsh         <= '0;
      snap        <= '0;
      resp_q      <= 1'b0;
      o_wr_strobe <= '0;
      for (int k = 0; k < REGS_NUM; k++) regs[k] <= '0;
    end else begin
      o_wr_strobe <= '0;
      resp_q      <= state == S_RESP;
      case (state)
        S_IDLE: if (acc) begin
          match <= hit;
          err   <= hit && rd != ASC_COLON;
          is_wr <= 1'b0;
          state <= !hit ? (rl ? S_IDLE : S_DRAIN) : rd == ASC_COLON ? S_INDEX : rl ? S_RESP : S_DRAIN;
        end
        S_INDEX: if (acc) begin
          idx   <= rd;
          err   <= err || rl || {1'b0, rd} >= RN;
          state <= rl ? S_RESP : S_CMD;
        end
        S_CMD: if (acc) begin
          is_wr <= is_w;
          bcnt  <= '0;
          snap  <= regs[idx_t];
          err   <= err || (!is_w && !is_r) || (is_w && rl);
          state <= rl ? S_RESP : is_w ? S_WDATA : S_DRAIN;
        end
        S_WDATA: if (acc) begin
          wsh  <= wnext;
          bcnt <= bcnt + 4'd1;
          if (last_b && !err) begin
            regs[idx_t]        <= wnext;
            o_wr_strobe[idx_t] <= 1'b1;
          end
          err   <= err || (rl && !last_b);
          state <= rl ? S_RESP : last_b ? S_DRAIN : S_WDATA;
        end
        S_DRAIN: if (acc && rl) state <= match ? S_RESP : S_IDLE;
        S_RESP: if (done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  udp_resp_serializer #(.REG_WIDTH(REG_WIDTH)) u_ser (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (ld),
    .i_hdr     (hdr),
    .i_payload (snap),
    .i_len     (len),
    .tx        (tx_udp_payload_axis),
    .o_done    (done)
  );
endmodule
